// File: rtl/time_set_editor.sv
// rtl/time_set_editor.sv - MM:SS preset editor with digit cursor, per-digit BCD limits and cursor blink.
module time_set_editor #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [15:0] time_in,
  output logic [15:0] digits,
  output logic [1:0]  cursor,
  output logic [3:0]  blank,
  output logic        editing,
  output logic        load
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  typedef enum logic {IDLE, EDIT} state_t;

  state_t        state, state_n;
  logic [15:0]   digits_n;
  logic [1:0]    cursor_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          phase, phase_n;
  logic          load_n;
  logic [3:0]    sel, sel_n, lim;
  logic          any_pulse;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] l);
    return (v > l) ? l : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      digits <= 16'h0000;
      cursor <= 2'd0;
      cnt    <= '0;
      phase  <= 1'b0;
      load   <= 1'b0;
    end else begin
      state  <= state_n;
      digits <= digits_n;
      cursor <= cursor_n;
      cnt    <= cnt_n;
      phase  <= phase_n;
      load   <= load_n;
    end
  end

  always_comb begin
    state_n   = state;
    digits_n  = digits;
    cursor_n  = cursor;
    cnt_n     = cnt;
    phase_n   = phase;
    load_n    = 1'b0;
    lim       = cursor[0] ? 4'd5 : 4'd9;
    sel       = digits[{cursor, 2'b00} +: 4];
    sel_n     = sel;
    any_pulse = up | down | left | right;

    case (state)
      IDLE: begin
        cnt_n   = '0;
        phase_n = 1'b0;
        if (set) begin
          state_n  = EDIT;
          digits_n = {clamp(time_in[15:12], 4'd5), clamp(time_in[11:8], 4'd9),
                      clamp(time_in[7:4], 4'd5),   clamp(time_in[3:0], 4'd9)};
          cursor_n = 2'd0;
        end
      end
      EDIT: begin
        if (!set) begin
          // Exit takes priority over any pulse seen in the same cycle.
          state_n = IDLE;
          load_n  = 1'b1;
          cnt_n   = '0;
          phase_n = 1'b0;
        end else begin
          if (up && !down)
            sel_n = (sel == lim) ? 4'd0 : 4'(sel + 4'd1);
          else if (down && !up)
            sel_n = (sel == 4'd0) ? lim : 4'(sel - 4'd1);
          digits_n[{cursor, 2'b00} +: 4] = sel_n;

          if (left && !right)
            cursor_n = 2'(cursor + 2'd1);
          else if (right && !left)
            cursor_n = 2'(cursor - 2'd1);

          // Restart the blink on any key so the selected digit shows at once.
          if (any_pulse) begin
            cnt_n   = '0;
            phase_n = 1'b0;
          end else if (cnt == CNT_MAX) begin
            cnt_n   = '0;
            phase_n = ~phase;
          end else begin
            cnt_n = CW'(cnt + 1'b1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    editing = (state == EDIT);
    blank   = phase ? (4'b0001 << cursor) : 4'b0000;
  end

endmodule

// File: doc/time_set_editor.md
# time_set_editor

Consumes the debounced, single-cycle button pulses and the `set` edit-mode level produced by the stopwatch button controller, and turns them into an edited MM:SS preset. While in edit mode it keeps a digit cursor, increments or decrements the selected BCD digit with per-digit limits, and drives a blink mask for the display. On leaving edit mode it issues a one-cycle `load` strobe so the stopwatch counter can take `digits` as its new value.

## Interface
Parameters:
- `BLINK_DIV`, default 25_000_000: clk cycles per blink half-period. Minimum 2; benches use 4.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `set`  in  1  edit-mode level; 1 = editing requested
- `up`  in  1  one-cycle pulse: increment selected digit
- `down`  in  1  one-cycle pulse: decrement selected digit
- `left`  in  1  one-cycle pulse: move cursor one digit left
- `right`  in  1  one-cycle pulse: move cursor one digit right
- `time_in`  in  16  current stopwatch time as BCD {m_tens, m_ones, s_tens, s_ones}; captured on edit entry
- `digits`  out  16  edited time, same BCD layout as `time_in`
- `cursor`  out  2  selected digit: 0 = s_ones, 1 = s_tens, 2 = m_ones, 3 = m_tens
- `blank`  out  4  per-digit blank mask for the display (bit i blanks digit i)
- `editing`  out  1  1 while in EDIT
- `load`  out  1  one-cycle strobe on exit from EDIT

## Operation
- Two-state FSM: IDLE and EDIT.
  - IDLE -> EDIT when `set`=1 is sampled.
  - EDIT -> IDLE when `set`=0 is sampled.
- Entering EDIT, all in the same edge:
  - `digits` <= `time_in`, with each nibble clamped to its limit.
  - `cursor` <= 0.
  - Blink counter and blink phase cleared.
- Digit limits: ones digits (0, 2) run 0–9; tens digits (1, 3) run 0–5.
- `up` in EDIT: selected digit +1; at its limit it wraps to 0. No carry into neighbouring digits.
- `down` in EDIT: selected digit −1; at 0 it wraps to its limit. No borrow.
- `up` and `down` in the same cycle: digit unchanged.
- `left` in EDIT: `cursor` +1, wrapping 3 -> 0.
- `right` in EDIT: `cursor` −1, wrapping 0 -> 3.
- `left` and `right` in the same cycle: cursor unchanged.
- Digit edit and cursor move in the same cycle: the edit applies to the old cursor position, and the cursor moves in the same edge.
- In IDLE, `up`/`down`/`left`/`right` are ignored; `digits` and `cursor` hold.
- Leaving EDIT: `load`=1 for exactly one cycle; `digits` holds its final value indefinitely through IDLE.
- Blink, EDIT only:
  - Counter runs 0..BLINK_DIV−1; phase toggles on wrap.
  - `blank` = phase ? onehot(`cursor`) : 4'b0000.
  - Any `up`/`down`/`left`/`right` pulse in EDIT clears counter and phase, so the selected digit is visible immediately.
- In IDLE, `blank`=0 and the counter is held at 0.
- Reset values: state IDLE, `digits`=16'h0000, `cursor`=0, `blank`=0, `editing`=0, `load`=0, counter=0, phase=0.

## Timing
- All outputs are registered. Inputs are sampled at edge N; the effect is visible after edge N.
- Edit-entry latency: `set` sampled high at edge N -> `editing`=1 and `digits`=clamped `time_in` after edge N.
- Edit-exit latency: `set` sampled low at edge N -> `load`=1 and `editing`=0 after edge N; `load`=0 after edge N+1.
- A pulse arriving in the same cycle that `set` is first sampled high is ignored (state is still IDLE).
- A pulse arriving in the cycle `set` is first sampled low is ignored (exit wins).
- First blink: with no pulses, `blank` first becomes non-zero BLINK_DIV cycles after EDIT entry.
- `rst` asserted mid-edit: all state returns to reset values immediately; no `load` is issued.

## Test plan
- Reset, then `set`=1 with `time_in`=16'h1234 -> `editing`=1, `digits`=16'h1234, `cursor`=0, `load`=0.
- Cursor 0 at value 4: six `up` pulses -> s_ones 5,6,7,8,9,0; one `down` -> 9; `up`+`down` together -> stays 9.
- One `left` (cursor 1), s_tens=3: three `up` pulses -> 4,5,0; `down` -> 5; `time_in`=16'h9F9F on entry -> `digits`=16'h5959.
- From cursor 0, four `left` pulses -> 1,2,3,0; `right` from 0 -> 3; `up`+`left` at cursor 3, m_tens=1 -> m_tens=2 and `cursor`=0 in the same edge.
- `BLINK_DIV`=4, in EDIT at cursor 2, no pulses -> `blank` toggles 0000/0100 every 4 cycles; an `up` pulse -> `blank`=0 the next cycle and the count restarts.
- `set` 1->0 -> `load` high exactly 1 cycle, `digits` held; `up`/`left` pulses in IDLE change nothing; `rst` mid-edit -> `digits`=0 with no `load`.
